// File: rtl/pacman_pkg.sv
// ---------------------------------------------------------------------------
// pacman_pkg
// Purpose : Shared definitions for the maze/ghost logic: direction codes,
//           direction width, maze extents and the ghost movement FSM states.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package pacman_pkg;

  // Direction encoding; dir ^ 2 is always the reverse direction.
  localparam int DIR_W = 2;
  localparam logic [DIR_W-1:0] DIR_N = 2'd0;  // y - 1
  localparam logic [DIR_W-1:0] DIR_E = 2'd1;  // x + 1
  localparam logic [DIR_W-1:0] DIR_S = 2'd2;  // y + 1
  localparam logic [DIR_W-1:0] DIR_W_ = 2'd3; // x - 1

  // Maze extents (last column / last row).
  localparam int MAZE_MAX_X = 27;
  localparam int MAZE_MAX_Y = 30;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_CHOOSE = 2'd2,
    ST_MOVE   = 2'd3
  } ghost_state_t;

endpackage

// File: rtl/ghost_dir_pick.sv
// ---------------------------------------------------------------------------
// ghost_dir_pick
// Purpose : Combinational choice of the ghost's next direction. The reverse
//           of the current direction is excluded unless it is the only exit.
//           Candidates are scanned upward (mod 4) from rand_sel; the first
//           open candidate wins. With no exits at all, cur_dir is kept.
// Ports   : open     [3:0] open mask {W,S,E,N}, bit i = direction i passable
//           cur_dir  [1:0] current direction
//           rand_sel [1:0] scan start direction
//           next_dir [1:0] selected direction
// ---------------------------------------------------------------------------
module ghost_dir_pick
  import pacman_pkg::*;
(
  input  logic [3:0]       open,
  input  logic [DIR_W-1:0] cur_dir,
  input  logic [DIR_W-1:0] rand_sel,
  output logic [DIR_W-1:0] next_dir
);

  logic [3:0]       cand;
  logic [DIR_W-1:0] idx;

  always_comb begin
    cand = open & ~(4'b0001 << (cur_dir ^ 2'd2));
    if (cand == 4'b0000) begin
      cand = open;
    end
    next_dir = cur_dir;
    idx      = '0;
    // Scan from the farthest offset down so the nearest hit overrides.
    for (int i = 3; i >= 0; i--) begin
      idx = rand_sel + 2'(i);
      if (cand[idx]) begin
        next_dir = idx;
      end
    end
  end

endmodule

// File: rtl/ghost_move_ctrl.sv
// ---------------------------------------------------------------------------
// ghost_move_ctrl
// Purpose : Moves one ghost one tile per move_tick. Queries the maze map for
//           the open-direction mask of the current tile (req/ack), picks a
//           legal direction at random, then steps one tile with horizontal
//           tunnel wrap and vertical clamping.
// Ports   : clk, reset (async, active-high)
//           move_tick          one-cycle request to advance one tile
//           rand_in   [7:0]    random byte, [1:0] sampled in CHOOSE
//           map_req            tile query, held until map_ack
//           map_x/map_y        query coordinates (= ghost position)
//           map_ack, map_open  map response and open mask {W,S,E,N}
//           ghost_x/ghost_y    current tile
//           ghost_dir [1:0]    current direction (0=N 1=E 2=S 3=W)
//           moved              one-cycle pulse after a position update
//           busy               high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module ghost_move_ctrl
  import pacman_pkg::*;
#(
  parameter int X_W     = 5,
  parameter int Y_W     = 5,
  parameter int MAX_X   = MAZE_MAX_X,
  parameter int MAX_Y   = MAZE_MAX_Y,
  parameter int START_X = 13,
  parameter int START_Y = 11,
  parameter int START_D = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             move_tick,
  input  logic [7:0]       rand_in,
  output logic             map_req,
  output logic [X_W-1:0]   map_x,
  output logic [Y_W-1:0]   map_y,
  input  logic             map_ack,
  input  logic [3:0]       map_open,
  output logic [X_W-1:0]   ghost_x,
  output logic [Y_W-1:0]   ghost_y,
  output logic [DIR_W-1:0] ghost_dir,
  output logic             moved,
  output logic             busy
);

  localparam logic [X_W-1:0]   MAX_X_L   = X_W'(MAX_X);
  localparam logic [Y_W-1:0]   MAX_Y_L   = Y_W'(MAX_Y);
  localparam logic [X_W-1:0]   START_X_L = X_W'(START_X);
  localparam logic [Y_W-1:0]   START_Y_L = Y_W'(START_Y);
  localparam logic [DIR_W-1:0] START_D_L = DIR_W'(START_D);

  ghost_state_t     state_reg, state_next;
  logic [3:0]       mask_reg;
  logic [DIR_W-1:0] pick_dir;
  logic [X_W-1:0]   x_next;
  logic [Y_W-1:0]   y_next;

  // Only the low two random bits steer the scan.
  logic unused_rand;
  assign unused_rand = ^rand_in[7:2];

  // The query always addresses the ghost's own tile.
  assign map_x = ghost_x;
  assign map_y = ghost_y;

  ghost_dir_pick u_pick (
    .open     (mask_reg),
    .cur_dir  (ghost_dir),
    .rand_sel (rand_in[1:0]),
    .next_dir (pick_dir)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (move_tick) state_next = ST_REQ;
      ST_REQ:    if (map_ack)   state_next = ST_CHOOSE;
      ST_CHOOSE: state_next = ST_MOVE;
      ST_MOVE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // One-tile step in the current direction: tunnel wrap on x, clamp on y.
  always_comb begin
    x_next = ghost_x;
    y_next = ghost_y;
    case (ghost_dir)
      DIR_N:   if (ghost_y != '0)      y_next = ghost_y - 1'b1;
      DIR_E:   x_next = (ghost_x == MAX_X_L) ? '0 : ghost_x + 1'b1;
      DIR_S:   if (ghost_y != MAX_Y_L) y_next = ghost_y + 1'b1;
      default: x_next = (ghost_x == '0) ? MAX_X_L : ghost_x - 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      mask_reg  <= '0;
      ghost_x   <= START_X_L;
      ghost_y   <= START_Y_L;
      ghost_dir <= START_D_L;
      map_req   <= 1'b0;
      moved     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_reg <= state_next;
      map_req   <= (state_next == ST_REQ);
      busy      <= (state_next != ST_IDLE);
      moved     <= (state_reg == ST_MOVE);
      case (state_reg)
        ST_REQ: begin
          if (map_ack) mask_reg <= map_open;
        end
        ST_CHOOSE: begin
          ghost_dir <= pick_dir;
        end
        ST_MOVE: begin
          // A tile with no exits keeps the ghost in place.
          if (mask_reg != 4'b0000) begin
            ghost_x <= x_next;
            ghost_y <= y_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ghost_move_ctrl.sv
module tb_ghost_move_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       move_tick;
  logic [7:0] rand_in;
  logic       map_req;
  logic [4:0] map_x;
  logic [4:0] map_y;
  logic       map_ack;
  logic [3:0] map_open;
  logic [4:0] ghost_x;
  logic [4:0] ghost_y;
  logic [1:0] ghost_dir;
  logic       moved;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference ghost state (plain integers).
  int m_x, m_y, m_dir;

  ghost_move_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .move_tick (move_tick),
    .rand_in   (rand_in),
    .map_req   (map_req),
    .map_x     (map_x),
    .map_y     (map_y),
    .map_ack   (map_ack),
    .map_open  (map_open),
    .ghost_x   (ghost_x),
    .ghost_y   (ghost_y),
    .ghost_dir (ghost_dir),
    .moved     (moved),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = 13; m_y = 11; m_dir = 3;
  endtask

  // Game rules: avoid reversing unless forced; scan from rsel upward.
  task automatic model_move(input int open, input int rsel);
    int rev, cand, d;
    rev  = (m_dir + 2) % 4;
    cand = open & ~(1 << rev);
    if (cand == 0) cand = open;
    if (open != 0) begin
      for (int k = 0; k < 4; k++) begin
        d = (rsel + k) % 4;
        if (((cand >> d) & 1) == 1) begin
          m_dir = d;
          break;
        end
      end
      case (m_dir)
        0: if (m_y > 0) m_y = m_y - 1;
        1: m_x = (m_x == 27) ? 0 : m_x + 1;
        2: if (m_y < 30) m_y = m_y + 1;
        default: m_x = (m_x == 0) ? 27 : m_x - 1;
      endcase
    end
  endtask

  task automatic check_pos(input string tag);
    check({tag, "_x"}, 32'(ghost_x), 32'(m_x));
    check({tag, "_y"}, 32'(ghost_y), 32'(m_y));
    check({tag, "_dir"}, 32'(ghost_dir), 32'(m_dir));
  endtask

  // One full transaction. skip_tick: FSM already in REQ (chained tick).
  // chain: assert a new tick in the moved cycle, leaving the FSM in REQ.
  task automatic do_move(input logic [3:0] open, input logic [1:0] rsel, input int delay,
                         input bit tick_busy, input bit skip_tick, input bit chain);
    int px, py, cnt;
    px = m_x; py = m_y;
    if (!skip_tick) begin
      @(negedge clk) move_tick = 1'b1;
      @(negedge clk) move_tick = 1'b0;
      check("req_rise", 32'(map_req), 1);
    end
    for (int i = 0; i < delay; i++) begin
      check("req_hold", 32'(map_req), 1);
      check("busy_hold", 32'(busy), 1);
      check("map_x", 32'(map_x), 32'(px));
      check("map_y", 32'(map_y), 32'(py));
      if (tick_busy) move_tick = 1'b1;
      @(negedge clk) move_tick = 1'b0;
    end
    map_ack  = 1'b1;
    map_open = open;
    rand_in  = {6'($urandom), rsel};
    model_move(int'(open), int'(rsel));
    @(negedge clk);
    map_ack  = 1'b0;
    map_open = 4'($urandom);
    check("req_drop", 32'(map_req), 0);
    if (tick_busy) move_tick = 1'b1;
    cnt = 0;
    while (!moved && cnt < 6) begin
      @(negedge clk);
      move_tick = 1'b0;
      rand_in = 8'($urandom);
      cnt++;
    end
    check("moved_lat", 32'(cnt), 2);
    check("moved", 32'(moved), 1);
    check_pos("pos");
    $display("move open=%b rand=%0d -> x=%0d y=%0d dir=%0d (exp %0d,%0d,%0d)",
             open, rsel, ghost_x, ghost_y, ghost_dir, m_x, m_y, m_dir);
    if (chain) move_tick = 1'b1;
    @(negedge clk) move_tick = 1'b0;
    check("moved_pulse", 32'(moved), 0);
    check("busy_after", 32'(busy), chain ? 1 : 0);
    if (chain) check("chain_req", 32'(map_req), 1);
  endtask

  initial begin
    reset = 1'b1; move_tick = 1'b0; rand_in = '0; map_ack = 1'b0; map_open = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_pos("rst");
    check("rst_req", 32'(map_req), 0);
    check("rst_moved", 32'(moved), 0);
    check("rst_busy", 32'(busy), 0);
    $display("reset idle x=%0d y=%0d dir=%0d", ghost_x, ghost_y, ghost_dir);

    // Ack with no request outstanding must be ignored.
    map_ack = 1'b1; map_open = 4'b1111;
    repeat (3) @(negedge clk);
    map_ack = 1'b0;
    check("noreq_busy", 32'(busy), 0);
    check_pos("noreq");

    do_move(4'b1010, 2'd0, 5, 1'b1, 1'b0, 1'b0);   // reverse E excluded
    do_move(4'b0010, 2'd0, 0, 1'b0, 1'b0, 1'b0);   // forced reverse to E
    do_move(4'b1000, 2'd1, 1, 1'b0, 1'b0, 1'b0);   // dead end, back to W
    do_move(4'b0010, 2'd3, 0, 1'b0, 1'b0, 1'b0);
    while (m_x != 27) do_move(4'b0010, 2'($urandom), 0, 1'b0, 1'b0, 1'b0);
    do_move(4'b0010, 2'd2, 0, 1'b0, 1'b0, 1'b0);   // east tunnel wrap to 0
    do_move(4'b1000, 2'd0, 0, 1'b0, 1'b0, 1'b0);   // west tunnel wrap to 27
    do_move(4'b0001, 2'd0, 0, 1'b0, 1'b0, 1'b0);   // now heading N
    do_move(4'b1111, 2'd2, 2, 1'b0, 1'b0, 1'b0);   // S excluded, scan 2->3 = W
    do_move(4'b0000, 2'd1, 0, 1'b0, 1'b0, 1'b0);   // no exits: stay put
    do_move(4'b0001, 2'd0, 0, 1'b0, 1'b0, 1'b1);   // chained tick in moved cycle
    do_move(4'b0001, 2'd0, 0, 1'b0, 1'b1, 1'b0);
    while (m_y != 0) do_move(4'b0001, 2'($urandom), 0, 1'b0, 1'b0, 1'b0);
    do_move(4'b0011, 2'd0, 0, 1'b0, 1'b0, 1'b0);   // N clamp at row 0
    do_move(4'b0100, 2'd2, 0, 1'b0, 1'b0, 1'b0);
    while (m_y != 30) do_move(4'b0100, 2'($urandom), 0, 1'b0, 1'b0, 1'b0);
    do_move(4'b0100, 2'd1, 0, 1'b0, 1'b0, 1'b0);   // S clamp at last row

    for (int n = 0; n < 150; n++) begin
      do_move(4'($urandom), 2'($urandom), int'($urandom_range(0, 3)),
              1'($urandom), 1'b0, 1'b0);
    end

    // Reset while waiting for the map: map_req drops without a clock edge.
    @(negedge clk) move_tick = 1'b1;
    @(negedge clk) move_tick = 1'b0;
    check("pre_rst_req", 32'(map_req), 1);
    #2 reset = 1'b1;
    #1 check("async_req", 32'(map_req), 0);
    check("async_busy", 32'(busy), 0);
    model_reset();
    check_pos("async");
    for (int i = 0; i < 4; i++) begin
      map_ack = 1'b1; map_open = 4'b1111; move_tick = 1'b1;
      @(negedge clk);
      check("rst_no_moved", 32'(moved), 0);
    end
    map_ack = 1'b0; move_tick = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_moved", 32'(moved), 0);
    check("post_rst_busy", 32'(busy), 0);
    check_pos("post_rst");
    $display("reset mid-op x=%0d y=%0d dir=%0d", ghost_x, ghost_y, ghost_dir);
    do_move(4'b0101, 2'd3, 1, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
